training_sequencer: RTL and testbench

TRAINING_SEQUENCER -- requirements
Module: training_sequencer

---
 rtl/training_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_training_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/training_sequencer.sv
// Training sequencer: resets and loads the network, then streams the sample
// memory into it for a fixed number of epochs with drain and reset gaps.
module training_sequencer #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned L1             = 2,
  parameter int unsigned SIZE_OF_X      = 2048,
  parameter int unsigned EPOCHS         = 100,
  parameter int unsigned SAMPLE_CYCLES  = 10,
  parameter int unsigned DRAIN_CYCLES   = 200,
  parameter int unsigned NET_RST_CYCLES = 10,
  parameter int unsigned LOAD_GAP       = 10
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  input  logic                             pause,
  output logic                             sample_rd_en,
  output logic [$clog2(SIZE_OF_X)-1:0]     sample_addr,
  input  logic [(L1+1)*DATA_W-1:0]         sample_data,
  output logic [L1*DATA_W-1:0]             a1_flat,
  output logic [DATA_W-1:0]                y_out,
  output logic                             net_reset,
  output logic                             block_reset_on_mux,
  output logic                             load_initial_parameters,
  output logic                             input_select,
  output logic                             en_forward,
  output logic                             en_backward,
  output logic [$clog2(EPOCHS+1)-1:0]      epoch_count,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned AW   = $clog2(SIZE_OF_X);
  localparam int unsigned EW   = $clog2(EPOCHS + 1);
  localparam int unsigned SW   = $clog2(SAMPLE_CYCLES);
  localparam int unsigned CMX1 = (NET_RST_CYCLES > LOAD_GAP) ? NET_RST_CYCLES : LOAD_GAP;
  localparam int unsigned CMAX = (CMX1 > DRAIN_CYCLES) ? CMX1 : DRAIN_CYCLES;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int unsigned FW   = L1 * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_RST,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_EPOCH_RST,
    S_DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   scnt;
  logic [AW-1:0]   index;
  logic            rd_q;

  // A read strobe held across a pause is suppressed and reissued on resume.
  assign sample_rd_en = rd_q & ~pause;
  assign sample_addr  = index;

  always_ff @(posedge clk) begin
    if (reset) begin
      state                   <= S_IDLE;
      cnt                     <= '0;
      scnt                    <= '0;
      index                   <= '0;
      rd_q                    <= 1'b0;
      a1_flat                 <= '0;
      y_out                   <= '0;
      net_reset               <= 1'b1;
      block_reset_on_mux      <= 1'b0;
      load_initial_parameters <= 1'b0;
      input_select            <= 1'b0;
      en_forward              <= 1'b0;
      en_backward             <= 1'b0;
      epoch_count             <= '0;
      busy                    <= 1'b0;
      done                    <= 1'b0;
    end else if (abort && state != S_IDLE) begin
      // Abandon the run; the network sees one reset cycle on the way out.
      state                   <= S_IDLE;
      cnt                     <= '0;
      scnt                    <= '0;
      index                   <= '0;
      rd_q                    <= 1'b0;
      net_reset               <= 1'b0;
      block_reset_on_mux      <= 1'b0;
      load_initial_parameters <= 1'b0;
      input_select            <= 1'b0;
      en_forward              <= 1'b0;
      en_backward             <= 1'b0;
      epoch_count             <= '0;
      busy                    <= 1'b0;
      done                    <= 1'b0;
    end else if (!pause) begin
      load_initial_parameters <= 1'b0;
      rd_q                    <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state              <= S_INIT_RST;
            cnt                <= '0;
            epoch_count        <= '0;
            net_reset          <= 1'b0;
            block_reset_on_mux <= 1'b0;
            input_select       <= 1'b0;
            busy               <= 1'b1;
            done               <= 1'b0;
          end else begin
            net_reset <= 1'b1;
          end
        end
        S_INIT_RST: begin
          if (cnt == CW'(NET_RST_CYCLES - 1)) begin
            state                   <= S_LOAD;
            cnt                     <= '0;
            net_reset               <= 1'b1;
            block_reset_on_mux      <= 1'b1;
            load_initial_parameters <= 1'b1;
            input_select            <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_LOAD: begin
          if (cnt == CW'(LOAD_GAP - 1)) begin
            state       <= S_STREAM;
            cnt         <= '0;
            scnt        <= '0;
            index       <= '0;
            rd_q        <= 1'b1;
            en_forward  <= 1'b1;
            en_backward <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STREAM: begin
          // Read data arrives during slot cycle 1 and is latched at its end.
          if (scnt == SW'(1)) begin
            a1_flat <= sample_data[FW-1:0];
            y_out   <= sample_data[FW +: DATA_W];
          end
          if (scnt == SW'(SAMPLE_CYCLES - 1)) begin
            scnt <= '0;
            if (index == AW'(SIZE_OF_X - 1)) begin
              state <= S_DRAIN;
              index <= '0;
              cnt   <= '0;
            end else begin
              index <= index + AW'(1);
              rd_q  <= 1'b1;
            end
          end else begin
            scnt <= scnt + SW'(1);
          end
        end
        S_DRAIN: begin
          if (cnt == CW'(DRAIN_CYCLES - 1)) begin
            cnt         <= '0;
            epoch_count <= epoch_count + EW'(1);
            if (epoch_count == EW'(EPOCHS - 1)) begin
              state       <= S_DONE;
              en_forward  <= 1'b0;
              en_backward <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end else begin
              state     <= S_EPOCH_RST;
              net_reset <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_EPOCH_RST: begin
          if (cnt == CW'(NET_RST_CYCLES - 1)) begin
            state        <= S_STREAM;
            cnt          <= '0;
            scnt         <= '0;
            index        <= '0;
            rd_q         <= 1'b1;
            net_reset    <= 1'b1;
            input_select <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_training_sequencer.sv
// Bench for training_sequencer: every cycle is compared with a timeline model
// of the run expressed as arithmetic on elapsed unpaused cycles.
module tb_training_sequencer;

  localparam int unsigned DW = 16;
  localparam int unsigned L1 = 2;
  localparam int unsigned SX = 4;
  localparam int unsigned EP = 2;
  localparam int unsigned SC = 10;
  localparam int unsigned DR = 20;
  localparam int unsigned NR = 10;
  localparam int unsigned LG = 10;
  localparam int unsigned AW = $clog2(SX);
  localparam int unsigned EW = $clog2(EP + 1);
  localparam int unsigned MW = (L1 + 1) * DW;

  localparam int SL    = SC * SX;
  localparam int PER   = SL + DR + NR;
  localparam int T0    = NR + LG;
  localparam int TDONE = T0 + EP * (SL + DR) + (EP - 1) * NR;

  logic                 clk = 1'b0;
  logic                 reset, start, abort, pause;
  logic                 sample_rd_en;
  logic [AW-1:0]        sample_addr;
  logic [MW-1:0]        sample_data;
  logic [L1*DW-1:0]     a1_flat;
  logic [DW-1:0]        y_out;
  logic                 net_reset, block_reset_on_mux, load_initial_parameters;
  logic                 input_select, en_forward, en_backward;
  logic [EW-1:0]        epoch_count;
  logic                 busy, done;

  always #5 clk = ~clk;

  training_sequencer #(
    .DATA_W(DW), .L1(L1), .SIZE_OF_X(SX), .EPOCHS(EP), .SAMPLE_CYCLES(SC),
    .DRAIN_CYCLES(DR), .NET_RST_CYCLES(NR), .LOAD_GAP(LG)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pause(pause),
    .sample_rd_en(sample_rd_en), .sample_addr(sample_addr), .sample_data(sample_data),
    .a1_flat(a1_flat), .y_out(y_out), .net_reset(net_reset),
    .block_reset_on_mux(block_reset_on_mux),
    .load_initial_parameters(load_initial_parameters),
    .input_select(input_select), .en_forward(en_forward), .en_backward(en_backward),
    .epoch_count(epoch_count), .busy(busy), .done(done)
  );

  // Synchronous-read sample memory
  logic [MW-1:0] mem [SX];
  logic [MW-1:0] mem_q;
  always @(posedge clk) if (sample_rd_en) mem_q <= mem[sample_addr];
  assign sample_data = mem_q;

  typedef enum int {M_IDLE, M_ABORT, M_RUN} mode_t;
  typedef struct {
    bit nr, brm, load, isel, en, rd, busy, done;
    int addr, ec;
  } exp_t;

  mode_t            mode;
  int               t;
  int               checks = 0;
  int               passes = 0;
  int               cyc = 0;
  int               rd_cnt = 0;
  int               rd_cyc [SX];
  logic [L1*DW-1:0] exp_a1;
  logic [DW-1:0]    exp_y;

  // Expected outputs t unpaused cycles after a start was accepted.
  function automatic exp_t model_run(input int tt);
    exp_t m;
    int u, e, v;
    m.nr = 1; m.brm = (tt >= NR); m.load = (tt == NR); m.isel = 0; m.en = 0;
    m.rd = 0; m.busy = 1; m.done = 0; m.addr = 0; m.ec = 0;
    if (tt < NR) begin
      m.nr = 0;
    end else if (tt >= TDONE) begin
      m.busy = 0; m.done = 1; m.ec = EP; m.isel = (EP > 1);
    end else if (tt >= T0) begin
      u = tt - T0; e = u / PER; v = u % PER;
      m.en = 1; m.isel = (e >= 1); m.ec = e;
      if (v < SL) begin
        m.rd = (v % SC == 0); m.addr = v / SC;
      end else if (v >= SL + DR) begin
        m.ec = e + 1; m.nr = 0;
      end
    end
    return m;
  endfunction

  function automatic exp_t idle_exp(input bit aborted);
    exp_t m;
    m.nr = !aborted; m.brm = 0; m.load = 0; m.isel = 0; m.en = 0;
    m.rd = 0; m.busy = 0; m.done = 0; m.addr = 0; m.ec = 0;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s cycle=%0d t=%0d observed=%0h expected=%0h", tag, cyc, t, obs, expv);
  endtask

  task automatic check_all();
    exp_t m, p;
    if (mode == M_RUN) m = model_run(t);
    else m = idle_exp(mode == M_ABORT);
    if (pause) m.rd = 0;
    if (mode == M_RUN && t >= 2) begin
      p = model_run(t - 2);
      if (p.rd) begin
        exp_a1 = mem[p.addr][L1*DW-1:0];
        exp_y  = mem[p.addr][MW-1 -: DW];
      end
    end
    chk("net_reset",    64'(net_reset),               64'(m.nr));
    chk("blk_rst_mux",  64'(block_reset_on_mux),      64'(m.brm));
    chk("load_params",  64'(load_initial_parameters), 64'(m.load));
    chk("input_select", 64'(input_select),            64'(m.isel));
    chk("en_forward",   64'(en_forward),              64'(m.en));
    chk("en_backward",  64'(en_backward),             64'(m.en));
    chk("rd_en",        64'(sample_rd_en),            64'(m.rd));
    if (m.rd) chk("rd_addr", 64'(sample_addr), 64'(m.addr));
    chk("epoch_count",  64'(epoch_count),             64'(m.ec));
    chk("busy",         64'(busy),                    64'(m.busy));
    chk("done",         64'(done),                    64'(m.done));
    chk("a1_flat",      64'(a1_flat),                 64'(exp_a1));
    chk("y_out",        64'(y_out),                   64'(exp_y));
  endtask

  // One clock: drive inputs, check mid-cycle, then advance the model.
  task automatic step(input bit rs, input bit st, input bit ab, input bit pa);
    reset = rs; start = st; abort = ab; pause = pa;
    @(negedge clk);
    check_all();
    if (sample_rd_en === 1'b1) begin
      rd_cnt++;
      rd_cyc[sample_addr] = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rs) begin
      mode = M_IDLE; t = 0; exp_a1 = '0; exp_y = '0;
    end else if (ab && mode == M_RUN) begin
      mode = M_ABORT; t = 0;
    end else if (pa) begin
      // frozen
    end else if (mode != M_RUN) begin
      if (st) begin mode = M_RUN; t = 0; end
      else mode = M_IDLE;
    end else if (t >= TDONE) begin
      if (st) t = 0;
    end else begin
      t++;
    end
  endtask

  task automatic run_to(input int target, input bit rp, input bit rs_start);
    int n = 0;
    bit st, pa;
    while (!(mode == M_RUN && t == target) && n < 2000) begin
      st = rs_start && mode == M_RUN && t < TDONE - 1 && ($urandom_range(0, 31) == 0);
      pa = rp && ($urandom_range(0, 7) == 0);
      step(0, st, 0, pa);
      n++;
    end
    chk("reach_t", 64'(mode == M_RUN && t == target), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
    for (int k = 0; k < int'(SX); k++) rd_cyc[k] = 0;
    repeat (2) @(posedge clk);
    #1;
    mode = M_IDLE; t = 0; exp_a1 = '0; exp_y = '0;

    // Idle after reset; lone abort and pause have no effect
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);

    // Run 1: structured words, start and abort together in IDLE
    for (int k = 0; k < int'(SX); k++) mem[k] = {DW'(4096), DW'(k + 1), DW'(-k)};
    rd_cnt = 0;
    step(0, 1, 1, 0);
    run_to(TDONE, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    chk("rd_count_run", 64'(rd_cnt), 64'(SX * EP));

    // Run 2 from DONE with random data; pause over slot 0 of sample 2
    for (int k = 0; k < int'(SX); k++) mem[k] = MW'({$urandom, $urandom});
    step(0, 1, 0, 0);
    run_to(T0 + SC, 1, 1);
    run_to(T0 + 2 * SC, 0, 0);
    repeat (5) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    run_to(T0 + 3 * SC, 0, 0);
    step(0, 0, 0, 0);
    chk("paused_slot_len", 64'(rd_cyc[2] - rd_cyc[1]), 64'(SC + 5));
    chk("next_slot_len",   64'(rd_cyc[3] - rd_cyc[2]), 64'(SC));

    // Abort (with pause held) in the first drain
    run_to(T0 + SL + 10, 1, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Run 3: replay, start while busy, then reset during the epoch reset
    step(0, 1, 0, 0);
    run_to(T0 + 2 * SC, 1, 1);
    step(0, 1, 0, 0);
    run_to(T0 + SL + DR + 5, 1, 1);
    step(1, 1, 1, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Run 4: complete run with random pauses and ignored starts
    for (int k = 0; k < int'(SX); k++) mem[k] = MW'({$urandom, $urandom});
    step(0, 1, 0, 0);
    run_to(TDONE, 1, 1);
    repeat (3) step(0, 0, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
